// File: rtl/horner_pkg.sv
// horner_pkg: encodings shared by the Horner datapath and its ALU.
//   - opnd_sel_e : operand A/B select (M0/M1): X, S, H register, constant K
//   - k_sel_e    : constant K select (M2): zero, coef_a, coef_b, coef_c
//   - alu_op_e   : ALU operation (H input): add or multiply
//   - W_DEFAULT  : default data width
package horner_pkg;

  localparam int W_DEFAULT = 16;

  typedef enum logic [1:0] {
    SEL_X = 2'd0,
    SEL_S = 2'd1,
    SEL_H = 2'd2,
    SEL_K = 2'd3
  } opnd_sel_e;

  typedef enum logic [1:0] {
    K_ZERO = 2'd0,
    K_A    = 2'd1,
    K_B    = 2'd2,
    K_C    = 2'd3
  } k_sel_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_e;

endpackage

// File: rtl/horner_alu.sv
// horner_alu: shared combinational W-bit unsigned add / multiply.
//   a, b : operands (W bits)
//   op   : 1 = multiply (low W bits of product), 0 = add (mod 2^W)
//   y    : result (W bits)
//   ovf  : only with HORNER_OVF_EN; high when y is a truncated value
//          (non-zero upper product half, or add carry-out)
// Without HORNER_OVF_EN only the truncated result is built.
module horner_alu
  import horner_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] y
`ifdef HORNER_OVF_EN
  ,
  output logic         ovf
`endif
);

`ifdef HORNER_OVF_EN
  logic [2*W-1:0] prod;
  logic [W:0]     sum;

  always_comb begin
    // Zero-extend explicitly so the full product / carry are kept.
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sum  = {1'b0, a} + {1'b0, b};
    if (alu_op_e'(op) == OP_MUL) begin
      y   = prod[W-1:0];
      ovf = |prod[2*W-1:W];
    end else begin
      y   = sum[W-1:0];
      ovf = sum[W];
    end
  end
`else
  always_comb begin
    if (alu_op_e'(op) == OP_MUL) y = a * b;
    else                         y = a + b;
  end
`endif

endmodule

// File: rtl/horner_datapath.sv
// horner_datapath: operative stage driven cycle by cycle by the polynomial
// control FSM. Holds X, H and S, one shared ALU and a coefficient bank, and
// captures S into result on the rising edge of pronto.
//   clk, rst               : clock, asynchronous active-high reset
//   x_in                   : argument, loaded into X when LX=1
//   coef_a/coef_b/coef_c   : coefficient bank (K select 1/2/3)
//   M0, M1                 : ALU operand A/B select (X, S, H, K)
//   M2                     : constant K select (zero, a, b, c)
//   LX, LH, LS             : load enables for X, H, S
//   H                      : ALU op, 1 = multiply, 0 = add
//   pronto                 : control done level
//   result, result_valid   : captured S and its fresh flag
//   ovf                    : only with HORNER_OVF_EN; sticky truncation flag,
//                            frozen at capture while result_valid=1
module horner_datapath
  import horner_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] coef_a,
  input  logic [W-1:0] coef_b,
  input  logic [W-1:0] coef_c,
  input  logic [1:0]   M0,
  input  logic [1:0]   M1,
  input  logic [1:0]   M2,
  input  logic         LX,
  input  logic         LH,
  input  logic         LS,
  input  logic         H,
  input  logic         pronto,
  output logic [W-1:0] result,
`ifdef HORNER_OVF_EN
  output logic         ovf,
`endif
  output logic         result_valid
);

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] h_q, h_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] result_q, result_d;
  logic         result_valid_q, result_valid_d;
  logic         pronto_dly_q;   // registered pronto for edge detection
  logic         pronto_rise;

  logic [W-1:0] k_val;
  logic [W-1:0] opnd_a;
  logic [W-1:0] opnd_b;
  logic [W-1:0] alu_y;

  // Operand muxes. All reads see pre-edge register values, so S <= S + X
  // is a plain read-modify-write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    k_val = '0;
    unique case (k_sel_e'(M2))
      K_ZERO: k_val = '0;
      K_A:    k_val = coef_a;
      K_B:    k_val = coef_b;
      K_C:    k_val = coef_c;
    endcase

    opnd_a = '0;
    unique case (opnd_sel_e'(M0))
      SEL_X: opnd_a = x_q;
      SEL_S: opnd_a = s_q;
      SEL_H: opnd_a = h_q;
      SEL_K: opnd_a = k_val;
    endcase

    opnd_b = '0;
    unique case (opnd_sel_e'(M1))
      SEL_X: opnd_b = x_q;
      SEL_S: opnd_b = s_q;
      SEL_H: opnd_b = h_q;
      SEL_K: opnd_b = k_val;
    endcase
  end

`ifdef HORNER_OVF_EN
  logic alu_ovf;
  logic ovf_run_q, ovf_run_d;   // live sticky flag for the current run
  logic ovf_cap_q, ovf_cap_d;   // copy frozen with result
`endif

  horner_alu #(.W(W)) u_alu (
    .a  (opnd_a),
    .b  (opnd_b),
    .op (H),
    .y  (alu_y)
`ifdef HORNER_OVF_EN
    ,
    .ovf(alu_ovf)
`endif
  );

  always_comb begin
    pronto_rise = pronto & ~pronto_dly_q;
    x_d         = LX ? x_in  : x_q;
    h_d         = LH ? alu_y : h_q;
    s_d         = LS ? alu_y : s_q;
    result_d    = pronto_rise ? s_q : result_q;
    // A capture on the same edge as a new run's LX keeps the flag set.
    if (pronto_rise)  result_valid_d = 1'b1;
    else if (LX)      result_valid_d = 1'b0;
    else              result_valid_d = result_valid_q;
  end

`ifdef HORNER_OVF_EN
  always_comb begin
    // LX starts a fresh run; a truncating write on that same edge still counts.
    ovf_run_d = (LX ? 1'b0 : ovf_run_q) | ((LH | LS) & alu_ovf);
    ovf_cap_d = pronto_rise ? ovf_run_q : ovf_cap_q;
  end

  assign ovf = result_valid_q ? ovf_cap_q : ovf_run_q;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q            <= '0;
      h_q            <= '0;
      s_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      pronto_dly_q   <= 1'b0;
`ifdef HORNER_OVF_EN
      ovf_run_q      <= 1'b0;
      ovf_cap_q      <= 1'b0;
`endif
    end else begin
      x_q            <= x_d;
      h_q            <= h_d;
      s_q            <= s_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      pronto_dly_q   <= pronto;
`ifdef HORNER_OVF_EN
      ovf_run_q      <= ovf_run_d;
      ovf_cap_q      <= ovf_cap_d;
`endif
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule
